// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle sequencer.
//   state_t        : FSM state encodings (also exported on state_o for debug)
//   OP_*           : RV32I major opcodes (instr[6:0])
//   instr_class_t  : instruction class latched in DECODE
//   PCSEL_*        : pc_sel encodings driven alongside pc_we
//   classify()     : opcode -> class, CLS_NONE for anything not RV32I-supported
package rv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        CLS_NONE   = 4'd0,
        CLS_R      = 4'd1,
        CLS_I      = 4'd2,
        CLS_LOAD   = 4'd3,
        CLS_STORE  = 4'd4,
        CLS_BRANCH = 4'd5,
        CLS_JAL    = 4'd6,
        CLS_JALR   = 4'd7,
        CLS_LUI    = 4'd8,
        CLS_AUIPC  = 4'd9
    } instr_class_t;

    localparam logic [1:0] PCSEL_PLUS4  = 2'b00;
    localparam logic [1:0] PCSEL_BRANCH = 2'b01;
    localparam logic [1:0] PCSEL_JALR   = 2'b10;

    // CLS_NONE doubles as the "illegal opcode" result.
    function automatic instr_class_t classify(input logic [6:0] op);
        instr_class_t cls;
        case (op)
            OP_R:      cls = CLS_R;
            OP_I:      cls = CLS_I;
            OP_LOAD:   cls = CLS_LOAD;
            OP_STORE:  cls = CLS_STORE;
            OP_BRANCH: cls = CLS_BRANCH;
            OP_JAL:    cls = CLS_JAL;
            OP_JALR:   cls = CLS_JALR;
            OP_LUI:    cls = CLS_LUI;
            OP_AUIPC:  cls = CLS_AUIPC;
            default:   cls = CLS_NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter shared by the instruction-fetch and data-memory phases.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart the count (asserted on the cycle that enters a wait phase)
//   inc        : count one more cycle without ready
//   expire     : the count has reached MEM_TIMEOUT-1; one more not-ready cycle is a timeout
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic expire
);

    localparam int TW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    logic [TW-1:0] count_reg;

    // The controller leaves the wait phase (to TRAP) once expire meets a
    // not-ready cycle, so the counter never needs to saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (inc) begin
            count_reg <= count_reg + TW'(1);
        end
    end

    assign expire = (count_reg == TW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_seq_ctrl.sv
// Multi-cycle sequencer for the RV32I datapath: steps each instruction through
// FETCH, DECODE, EXEC, MEM and WB and issues the per-phase strobes.
//   clk, rst_n         : clock, asynchronous active-low reset
//   opcode             : instr[6:0] from the IR, consumed only in DECODE
//   branch_taken       : branch compare result, used in EXEC of a branch
//   imem_req/ready     : instruction fetch handshake
//   dmem_req/we/ready  : data memory handshake, we=1 for stores
//   ir_we, pc_we       : IR load / PC update pulses; pc_sel qualifies pc_we
//   reg_write          : register file write pulse
//   trap               : sticky illegal-opcode / memory-timeout flag
//   state_o            : current state for debug
//   retire_cnt         : completed-instruction count (wraps)
module multicycle_seq_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int RETIRE_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          opcode,
    input  logic                branch_taken,
    output logic                imem_req,
    input  logic                imem_ready,
    output logic                dmem_req,
    output logic                dmem_we,
    input  logic                dmem_ready,
    output logic                ir_we,
    output logic                pc_we,
    output logic [1:0]          pc_sel,
    output logic                reg_write,
    output logic                trap,
    output logic [2:0]          state_o,
    output logic [RETIRE_W-1:0] retire_cnt
);

    state_t                state_reg, state_next;
    instr_class_t          class_reg, class_next;
    logic [RETIRE_W-1:0]   retire_cnt_reg;
    logic                  timer_clear;
    logic                  timer_inc;
    logic                  timer_expire;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (timer_clear),
        .inc    (timer_inc),
        .expire (timer_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            class_reg      <= CLS_NONE;
            retire_cnt_reg <= '0;
        end else begin
            state_reg      <= state_next;
            class_reg      <= class_next;
            // An instruction retires exactly when its final phase updates the PC.
            if (pc_we) begin
                retire_cnt_reg <= retire_cnt_reg + RETIRE_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        class_next = class_reg;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = PCSEL_PLUS4;
        reg_write  = 1'b0;
        trap       = 1'b0;
        timer_inc  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                state_next = ST_FETCH;
            end

            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we      = 1'b1;
                    state_next = ST_DECODE;
                end else begin
                    timer_inc = 1'b1;
                    // ready in the expiring cycle still completes the fetch above.
                    if (timer_expire) begin
                        state_next = ST_TRAP;
                    end
                end
            end

            ST_DECODE: begin
                class_next = classify(opcode);
                state_next = (classify(opcode) == CLS_NONE) ? ST_TRAP : ST_EXEC;
            end

            ST_EXEC: begin
                case (class_reg)
                    CLS_LOAD, CLS_STORE: begin
                        state_next = ST_MEM;
                    end
                    CLS_BRANCH: begin
                        pc_we      = 1'b1;
                        pc_sel     = branch_taken ? PCSEL_BRANCH : PCSEL_PLUS4;
                        state_next = ST_FETCH;
                    end
                    default: begin
                        state_next = ST_WB;
                    end
                endcase
            end

            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (class_reg == CLS_STORE);
                if (dmem_ready) begin
                    if (class_reg == CLS_STORE) begin
                        pc_we      = 1'b1;
                        pc_sel     = PCSEL_PLUS4;
                        state_next = ST_FETCH;
                    end else begin
                        state_next = ST_WB;
                    end
                end else begin
                    timer_inc = 1'b1;
                    if (timer_expire) begin
                        state_next = ST_TRAP;
                    end
                end
            end

            ST_WB: begin
                reg_write  = 1'b1;
                pc_we      = 1'b1;
                if (class_reg == CLS_JAL) begin
                    pc_sel = PCSEL_BRANCH;
                end else if (class_reg == CLS_JALR) begin
                    pc_sel = PCSEL_JALR;
                end else begin
                    pc_sel = PCSEL_PLUS4;
                end
                state_next = ST_FETCH;
            end

            ST_TRAP: begin
                trap = 1'b1;
            end

            default: begin
                // Unused encoding 7: park in TRAP rather than wander.
                state_next = ST_TRAP;
            end
        endcase
    end

    // Restart the wait counter on the cycle that moves into a handshake phase.
    // FETCH and MEM are never adjacent to themselves across an entry, so a
    // state change into either one is exactly an entry.
    assign timer_clear = ((state_next == ST_FETCH) || (state_next == ST_MEM))
                         && (state_next != state_reg);

    assign state_o    = state_reg;
    assign retire_cnt = retire_cnt_reg;

endmodule
